sequential_divider: RTL and testbench



---
 rtl/sequential_divider.sv | 120 ++++++++++++
 tb/tb_sequential_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Sequential restoring divider: unsigned width-bit A / B, one quotient bit per clock.
// Shares the start/done/busy handshake of the shift-add multiplier; results are held until the next completion.
module sequential_divider #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             divzero
);

  localparam int unsigned CW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

  state_t           state, state_nx;
  logic [width-1:0] q_reg, q_nx;
  logic [width-1:0] d_reg, d_nx;
  logic [width-1:0] r_reg, r_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [width-1:0] quotient_nx, remainder_nx;
  logic             done_nx, busy_nx, divzero_nx;
  logic [width:0]   trial;
  logic [width-1:0] diff;
  logic             ge;

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_nx     = state;
    q_nx         = q_reg;
    d_nx         = d_reg;
    r_nx         = r_reg;
    cnt_nx       = cnt;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    divzero_nx   = divzero;

    // Partial remainder is always < D after a step, so its top bit is dropped from storage
    trial = {r_reg, q_reg[width-1]};
    ge    = (trial >= {1'b0, d_reg});
    diff  = width'(trial - {1'b0, d_reg});

    case (state)
      IDLE: begin
        if (start) begin
          q_nx = A;
          if (B != '0) begin
            r_nx     = '0;
            d_nx     = B;
            cnt_nx   = CW'(width);
            state_nx = RUN;
          end else begin
            state_nx = ZERO;
          end
        end
      end
      RUN: begin
        r_nx   = ge ? diff : trial[width-1:0];
        q_nx   = {q_reg[width-2:0], ge};
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx     = DONE;
          quotient_nx  = q_nx;
          remainder_nx = r_nx;
          divzero_nx   = 1'b0;
        end
      end
      ZERO: begin
        // q_reg still holds the dividend captured at start
        state_nx     = DONE;
        quotient_nx  = '1;
        remainder_nx = q_reg;
        divzero_nx   = 1'b1;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    done_nx = (state_nx == DONE);
    busy_nx = (state_nx == RUN) || (state_nx == ZERO);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      divzero   <= 1'b0;
    end else begin
      state     <= state_nx;
      q_reg     <= q_nx;
      d_reg     <= d_nx;
      r_reg     <= r_nx;
      cnt       <= cnt_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
      done      <= done_nx;
      busy      <= busy_nx;
      divzero   <= divzero_nx;
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider (width=4): driver pushes expected results,
// a negedge monitor checks results, latency, handshake and held outputs.
module tb_sequential_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] A, B;
  logic [3:0] quotient, remainder;
  logic       done, busy, divzero;

  sequential_divider #(.width(4)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .quotient(quotient), .remainder(remainder),
    .done(done), .busy(busy), .divzero(divzero)
  );

  typedef struct {
    int q;
    int r;
    int dz;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, divide-by-zero gives all ones and the dividend
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    e.q   = (b == 0) ? 15 : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dz  = (b == 0) ? 1 : 0;
    e.acc = acc;
    e.lat = (b == 0) ? 1 : 4;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  // Monitor: pops an expectation on every done, otherwise checks idle/busy and held outputs
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_flags", int'({done, busy, divzero}), 0);
      held = '{0, 0, 0, 0, 0};
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_width", int'(prev_done), 0);
        chk("busy_with_done", int'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          held = sb.pop_front();
          chk("quotient", int'(quotient), held.q);
          chk("remainder", int'(remainder), held.r);
          chk("divzero", int'(divzero), held.dz);
          chk("latency", cyc - held.acc, held.lat);
        end
      end else begin
        chk("busy", int'(busy), (sb.size() != 0) ? 1 : 0);
        chk("hold_quotient", int'(quotient), held.q);
        chk("hold_remainder", int'(remainder), held.r);
        chk("hold_divzero", int'(divzero), held.dz);
      end
      prev_done = done;
    end
  end

  // Bounded wait for done, then one more cycle so the DUT is back in IDLE
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      $display("FAIL done_timeout at cycle %0d: got no done expected done within 20 cycles", cyc);
      $fatal(1);
    end
    @(negedge clk);
  endtask

  // Issue one start at a negedge; operands are scrambled right after the accepting edge
  task automatic issue(input int a, input int b);
    start = 1'b1;
    A = 4'(a);
    B = 4'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(a, b, cyc));
    A = 4'($urandom);
    B = 4'($urandom);
  endtask

  task automatic do_op(input int a, input int b);
    issue(a, b);
    wait_done();
  endtask

  int order[256];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(13, 3);
    do_op(15, 1);
    do_op(5, 7);
    do_op(14, 14);
    do_op(15, 8);
    do_op(9, 0);
    do_op(6, 2);

    // Start pulsed mid-run with new operands must be ignored
    issue(13, 3);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    A = 4'd2;
    B = 4'd1;
    @(negedge clk);
    start = 1'b0;
    A = 4'd7;
    B = 4'd0;
    wait_done();

    // Asynchronous reset mid-run: operation abandoned, no done
    issue(13, 3);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    do_op(10, 4);

    // All 256 operand pairs in shuffled order, back-to-back at minimum spacing
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 256; k++) do_op(order[k] / 16, order[k] % 16);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
